// File: rtl/l2_icache_resp.sv
// L2 instruction-cache responder: queues icache READs, fetches lines from a backing store,
// returns FILLs and forwards external invalidates as one-cycle INV responses.
module l2_icache_resp #(
  parameter int unsigned CACHE_LINE = 512,
  parameter int unsigned ADDR_SZ    = 32,
  parameter int unsigned REQ_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            icache_l2_op,
  input  logic [ADDR_SZ-1:0]    icache_l2_addr,
  input  logic [CACHE_LINE-1:0] icache_l2_data_out,
  input  logic [3:0]            icache_l2_state,
  output logic [2:0]            l2_icache_op,
  output logic [ADDR_SZ-1:0]    l2_icache_addr,
  output logic [CACHE_LINE-1:0] l2_icache_data,
  output logic [3:0]            l2_icache_state,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_SZ-1:0]    mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [CACHE_LINE-1:0] mem_resp_data,
  input  logic                  inv_valid,
  input  logic [ADDR_SZ-1:0]    inv_addr,
  output logic                  overflow
);

  localparam int unsigned LB = CACHE_LINE / 8;
  localparam int unsigned PW = $clog2(REQ_DEPTH);
  localparam int unsigned CW = $clog2(REQ_DEPTH + 1);
  localparam logic [ADDR_SZ-1:0] AMASK = ~ADDR_SZ'(LB - 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_READ = 3'b001;
  localparam logic [2:0] OP_FILL = 3'b001;
  localparam logic [2:0] OP_INV  = 3'b010;
  localparam logic [3:0] ST_SHARED  = 4'b0010;
  localparam logic [3:0] ST_INVALID = 4'b0001;

  typedef enum logic [1:0] {StIdle, StMemReq, StMemWait, StResp} state_t;

  state_t                  state;
  logic [ADDR_SZ-1:0]      fifo_mem [REQ_DEPTH];
  logic [PW:0]             wr_ptr;
  logic [PW:0]             rd_ptr;
  logic [CW-1:0]           occ;
  logic [ADDR_SZ-1:0]      req_addr;
  logic [CACHE_LINE-1:0]   fill_data;
  logic                    inv_pend;
  logic [ADDR_SZ-1:0]      inv_pend_addr;

  logic q_empty;
  logic pop;
  logic release_slot;
  logic rd_req;
  logic push;
  logic drop;
  logic unused_inputs;

  // The in-flight request keeps its slot in the occupancy count until its FILL is issued,
  // so REQ_DEPTH bounds queued plus outstanding READs.
  always_comb begin
    q_empty      = (wr_ptr == rd_ptr);
    pop          = (state == StIdle) && !q_empty;
    release_slot = (state == StResp);
    rd_req       = (icache_l2_op == OP_READ);
    push         = rd_req && ((occ != CW'(REQ_DEPTH)) || release_slot);
    drop         = rd_req && !push;
  end

  assign unused_inputs = ^{icache_l2_data_out, icache_l2_state};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= icache_l2_addr & AMASK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= StIdle;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      req_addr        <= '0;
      fill_data       <= '0;
      inv_pend        <= 1'b0;
      inv_pend_addr   <= '0;
      overflow        <= 1'b0;
      mem_req_valid   <= 1'b0;
      mem_req_addr    <= '0;
      l2_icache_op    <= OP_NOP;
      l2_icache_addr  <= '0;
      l2_icache_data  <= '0;
      l2_icache_state <= 4'b0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      unique case ({push, release_slot})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase
      if (drop) overflow <= 1'b1;

      l2_icache_op    <= OP_NOP;
      l2_icache_addr  <= '0;
      l2_icache_data  <= '0;
      l2_icache_state <= 4'b0000;

      unique case (state)
        StIdle: begin
          if (!q_empty) begin
            req_addr      <= fifo_mem[rd_ptr[PW-1:0]];
            mem_req_valid <= 1'b1;
            mem_req_addr  <= fifo_mem[rd_ptr[PW-1:0]];
            state         <= StMemReq;
          end
        end
        StMemReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            state         <= StMemWait;
          end
        end
        StMemWait: begin
          if (mem_resp_valid) begin
            fill_data <= mem_resp_data;
            state     <= StResp;
          end
        end
        StResp: begin
          l2_icache_op    <= OP_FILL;
          l2_icache_addr  <= req_addr;
          l2_icache_data  <= fill_data;
          l2_icache_state <= ST_SHARED;
          state           <= StIdle;
        end
        default: state <= StIdle;
      endcase

      // FILL owns the response port in RESP; a pending INV waits one cycle.
      if (inv_pend && (state != StResp)) begin
        l2_icache_op    <= OP_INV;
        l2_icache_addr  <= inv_pend_addr;
        l2_icache_state <= ST_INVALID;
        inv_pend        <= 1'b0;
      end
      if (inv_valid) begin
        inv_pend      <= 1'b1;
        inv_pend_addr <= inv_addr & AMASK;
      end
    end
  end

endmodule

// File: tb/tb_l2_icache_resp.sv
// Directed self-checking bench for l2_icache_resp at default parameters.
module tb_l2_icache_resp;

  localparam int CL = 512;
  localparam int AW = 32;
  localparam logic [2:0] NOP = 3'b000, READ = 3'b001, FILL = 3'b001, INV = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    icache_l2_op;
  logic [AW-1:0] icache_l2_addr;
  logic [CL-1:0] icache_l2_data_out;
  logic [3:0]    icache_l2_state;
  logic [2:0]    l2_icache_op;
  logic [AW-1:0] l2_icache_addr;
  logic [CL-1:0] l2_icache_data;
  logic [3:0]    l2_icache_state;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid;
  logic [CL-1:0] mem_resp_data;
  logic          inv_valid;
  logic [AW-1:0] inv_addr;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0]    ev_op[$];
  logic [AW-1:0] ev_addr[$];
  logic [CL-1:0] ev_data[$];
  logic [3:0]    ev_state[$];

  l2_icache_resp dut (
    .clk                (clk),
    .rst                (rst),
    .icache_l2_op       (icache_l2_op),
    .icache_l2_addr     (icache_l2_addr),
    .icache_l2_data_out (icache_l2_data_out),
    .icache_l2_state    (icache_l2_state),
    .l2_icache_op       (l2_icache_op),
    .l2_icache_addr     (l2_icache_addr),
    .l2_icache_data     (l2_icache_data),
    .l2_icache_state    (l2_icache_state),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data),
    .inv_valid          (inv_valid),
    .inv_addr           (inv_addr),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want normal completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CL-1:0] exp_data(input logic [AW-1:0] a);
    return {(CL/32){a ^ 32'hC0DE_0000}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_op.delete(); ev_addr.delete(); ev_data.delete(); ev_state.delete();
  endtask

  // Backing-store model: answers every accepted request one cycle later and logs responses.
  task automatic drain(input int n);
    logic          acc;
    logic [AW-1:0] a;
    for (int c = 0; c < n; c++) begin
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      tick();
      mem_resp_valid = acc;
      mem_resp_data  = acc ? exp_data(a) : '0;
      if (l2_icache_op != NOP) begin
        ev_op.push_back(l2_icache_op);
        ev_addr.push_back(l2_icache_addr);
        ev_data.push_back(l2_icache_data);
        ev_state.push_back(l2_icache_state);
      end
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    icache_l2_op = NOP; icache_l2_addr = '0; icache_l2_data_out = '1; icache_l2_state = 4'hF;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    inv_valid = 1'b0; inv_addr = '0;
    repeat (3) tick();
    n_checks++; if (l2_icache_op !== NOP) $display("FAIL reset_op: got %b want 000", l2_icache_op); else n_pass++;
    n_checks++; if (l2_icache_addr !== '0) $display("FAIL reset_addr: got %h want 0", l2_icache_addr); else n_pass++;
    n_checks++; if (l2_icache_data !== '0) $display("FAIL reset_data: got nonzero want 0"); else n_pass++;
    n_checks++; if (l2_icache_state !== 4'b0000) $display("FAIL reset_state: got %b want 0000", l2_icache_state); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (mem_req_addr !== '0) $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    rst = 1'b1;
  endtask

  // First READ right after reset release; also checks exact 4-cycle latency.
  task automatic test_single_read();
    mem_req_ready = 1'b1;
    icache_l2_op = READ; icache_l2_addr = 32'h0000_1010;
    tick();
    icache_l2_op = NOP;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL single_early_req: got %b want 0", mem_req_valid); else n_pass++;
    tick();
    n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL single_req_valid: got %b want 1", mem_req_valid); else n_pass++;
    n_checks++; if (mem_req_addr !== 32'h0000_1000) $display("FAIL single_req_addr: got %h want 00001000", mem_req_addr); else n_pass++;
    tick();
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL single_req_drop: got %b want 0", mem_req_valid); else n_pass++;
    mem_resp_valid = 1'b1; mem_resp_data = {(CL/8){8'hA5}};
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    n_checks++; if (l2_icache_op !== NOP) $display("FAIL single_early_fill: got %b want 000", l2_icache_op); else n_pass++;
    tick();
    n_checks++; if (l2_icache_op !== FILL) $display("FAIL single_fill_op: got %b want 001", l2_icache_op); else n_pass++;
    n_checks++; if (l2_icache_addr !== 32'h0000_1000) $display("FAIL single_fill_addr: got %h want 00001000", l2_icache_addr); else n_pass++;
    n_checks++; if (l2_icache_data !== {(CL/8){8'hA5}}) $display("FAIL single_fill_data: got %h want all a5", l2_icache_data[31:0]); else n_pass++;
    n_checks++; if (l2_icache_state !== 4'b0010) $display("FAIL single_fill_state: got %b want 0010", l2_icache_state); else n_pass++;
    tick();
    n_checks++; if (l2_icache_op !== NOP) $display("FAIL single_after_op: got %b want 000", l2_icache_op); else n_pass++;
    n_checks++; if (l2_icache_data !== '0) $display("FAIL single_after_data: got nonzero want 0"); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    clear_events();
    mem_req_ready = 1'b0;
    icache_l2_op = READ;
    icache_l2_addr = 32'h0000_1000; tick();
    icache_l2_addr = 32'h0000_2000; tick();
    icache_l2_addr = 32'h0000_3000; tick();
    icache_l2_op = NOP; icache_l2_addr = '0;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    n_checks++; if (mem_req_addr !== 32'h0000_1000) $display("FAIL ovf_req_addr: got %h want 00001000", mem_req_addr); else n_pass++;
    mem_req_ready = 1'b1;
    drain(24);
    n_checks++; if (ev_op.size() !== 2) $display("FAIL ovf_fill_count: got %0d want 2", ev_op.size()); else n_pass++;
    if (ev_op.size() >= 2) begin
      n_checks++; if (ev_addr[0] !== 32'h0000_1000) $display("FAIL ovf_fill0_addr: got %h want 00001000", ev_addr[0]); else n_pass++;
      n_checks++; if (ev_addr[1] !== 32'h0000_2000) $display("FAIL ovf_fill1_addr: got %h want 00002000", ev_addr[1]); else n_pass++;
      n_checks++; if (ev_op[1] !== FILL) $display("FAIL ovf_fill1_op: got %b want 001", ev_op[1]); else n_pass++;
      n_checks++; if (ev_data[1] !== exp_data(32'h0000_2000)) $display("FAIL ovf_fill1_data: got %h want %h", ev_data[1][31:0], exp_data(32'h0000_2000) & 32'hFFFF_FFFF); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  // Brings a READ to the cycle just before its RESP edge (state RESP).
  task automatic read_to_resp(input logic [AW-1:0] a, input logic [CL-1:0] d);
    mem_req_ready = 1'b1;
    icache_l2_op = READ; icache_l2_addr = a;
    tick();
    icache_l2_op = NOP;
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = d;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_fill_inv_collision();
    read_to_resp(32'h0000_5000, {(CL/8){8'h3C}});
    inv_valid = 1'b1; inv_addr = 32'h0000_407F;
    tick();
    inv_valid = 1'b0; inv_addr = '0;
    n_checks++; if (l2_icache_op !== FILL) $display("FAIL coll_fill_op: got %b want 001", l2_icache_op); else n_pass++;
    n_checks++; if (l2_icache_addr !== 32'h0000_5000) $display("FAIL coll_fill_addr: got %h want 00005000", l2_icache_addr); else n_pass++;
    tick();
    n_checks++; if (l2_icache_op !== INV) $display("FAIL coll_inv_op: got %b want 010", l2_icache_op); else n_pass++;
    n_checks++; if (l2_icache_addr !== 32'h0000_4040) $display("FAIL coll_inv_addr: got %h want 00004040", l2_icache_addr); else n_pass++;
    n_checks++; if (l2_icache_state !== 4'b0001) $display("FAIL coll_inv_state: got %b want 0001", l2_icache_state); else n_pass++;
    n_checks++; if (l2_icache_data !== '0) $display("FAIL coll_inv_data: got nonzero want 0"); else n_pass++;
    tick();
    n_checks++; if (l2_icache_op !== NOP) $display("FAIL coll_after_op: got %b want 000", l2_icache_op); else n_pass++;
  endtask

  task automatic test_inv_overwrite();
    int n_inv;
    mem_req_ready = 1'b1;
    icache_l2_op = READ; icache_l2_addr = 32'h0000_9000;
    tick();
    icache_l2_op = NOP;
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = {(CL/8){8'h5A}};
    inv_valid = 1'b1; inv_addr = 32'h0000_0100;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    inv_addr = 32'h0000_0200;
    tick();
    inv_valid = 1'b0; inv_addr = '0;
    n_checks++; if (l2_icache_op !== FILL) $display("FAIL ovw_fill_op: got %b want 001", l2_icache_op); else n_pass++;
    clear_events();
    drain(8);
    n_inv = 0;
    foreach (ev_op[i]) if (ev_op[i] == INV) n_inv++;
    n_checks++; if (n_inv !== 1) $display("FAIL ovw_inv_count: got %0d want 1", n_inv); else n_pass++;
    if (ev_op.size() >= 1) begin
      n_checks++; if (ev_addr[0] !== 32'h0000_0200) $display("FAIL ovw_inv_addr: got %h want 00000200", ev_addr[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    read_to_resp_wait(32'h0000_6000);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rstmid_req_valid: got %b want 0", mem_req_valid); else n_pass++;
    tick();
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = '1;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    clear_events();
    drain(8);
    n_checks++; if (ev_op.size() !== 0) $display("FAIL rstmid_no_fill: got %0d responses want 0", ev_op.size()); else n_pass++;
    n_checks++; if ({l2_icache_op, l2_icache_addr, l2_icache_state} !== '0) $display("FAIL rstmid_outputs: got op %b addr %h want 0", l2_icache_op, l2_icache_addr); else n_pass++;
    n_checks++; if ({mem_req_valid, mem_req_addr} !== '0) $display("FAIL rstmid_mem_outputs: got %b %h want 0", mem_req_valid, mem_req_addr); else n_pass++;
    icache_l2_op = READ; icache_l2_addr = 32'h0000_7020;
    tick();
    icache_l2_op = NOP;
    clear_events();
    drain(10);
    n_checks++; if (ev_op.size() !== 1) $display("FAIL rstmid_next_count: got %0d want 1", ev_op.size()); else n_pass++;
    if (ev_op.size() >= 1) begin
      n_checks++; if (ev_addr[0] !== 32'h0000_7000) $display("FAIL rstmid_next_addr: got %h want 00007000", ev_addr[0]); else n_pass++;
      n_checks++; if (ev_data[0] !== exp_data(32'h0000_7000)) $display("FAIL rstmid_next_data: got %h want %h", ev_data[0][31:0], exp_data(32'h0000_7000) & 32'hFFFF_FFFF); else n_pass++;
    end
  endtask

  // Leaves the DUT in MEM_WAIT (request accepted, no response yet).
  task automatic read_to_resp_wait(input logic [AW-1:0] a);
    mem_req_ready = 1'b1;
    icache_l2_op = READ; icache_l2_addr = a;
    tick();
    icache_l2_op = NOP;
    tick();
    tick();
  endtask

  task automatic test_ready_stall();
    mem_req_ready = 1'b0;
    icache_l2_op = READ; icache_l2_addr = 32'h0000_8047;
    tick();
    icache_l2_op = NOP;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL stall_valid_c%0d: got %b want 1", c, mem_req_valid); else n_pass++;
      n_checks++; if (mem_req_addr !== 32'h0000_8040) $display("FAIL stall_addr_c%0d: got %h want 00008040", c, mem_req_addr); else n_pass++;
    end
    mem_req_ready = 1'b1;
    clear_events();
    drain(10);
    n_checks++; if (ev_op.size() !== 1) $display("FAIL stall_fill_count: got %0d want 1", ev_op.size()); else n_pass++;
    if (ev_op.size() >= 1) begin
      n_checks++; if (ev_addr[0] !== 32'h0000_8040) $display("FAIL stall_fill_addr: got %h want 00008040", ev_addr[0]); else n_pass++;
      n_checks++; if (ev_state[0] !== 4'b0010) $display("FAIL stall_fill_state: got %b want 0010", ev_state[0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_overflow();
    test_fill_inv_collision();
    test_inv_overwrite();
    test_reset_mid();
    test_ready_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_icache_resp.md
L2_ICACHE_RESP -- requirements
Module: l2_icache_resp

Interface
REQ-001 Parameter CACHE_LINE, default 512, line width in bits; line bytes LB = CACHE_LINE/8.
REQ-002 Parameter ADDR_SZ, default 32, address width in bits.
REQ-003 Parameter REQ_DEPTH, default 2, request FIFO entries (power of two, >=2).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL expose these ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- icache_l2_op  in  3  icache request: 000 NOP, 001 READ; other codes ignored
- icache_l2_addr  in  ADDR_SZ  request address
- icache_l2_data_out  in  CACHE_LINE  unused by this block
- icache_l2_state  in  4  unused by this block
- l2_icache_op  out  3  response: 000 NOP, 001 FILL, 010 INV
- l2_icache_addr  out  ADDR_SZ  line-aligned response address
- l2_icache_data  out  CACHE_LINE  fill data
- l2_icache_state  out  4  0010 SHARED on FILL, 0001 INVALID on INV, 0000 otherwise
- mem_req_valid  out  1  backing-store read request
- mem_req_ready  in  1  backing store accepts request
- mem_req_addr  out  ADDR_SZ  line-aligned read address
- mem_resp_valid  in  1  read data valid, one cycle
- mem_resp_data  in  CACHE_LINE  read data
- inv_valid  in  1  external invalidate pulse
- inv_addr  in  ADDR_SZ  invalidate address
- overflow  out  1  sticky: READ dropped because FIFO was full

Function
REQ-006 Line alignment SHALL clear the low log2(LB) address bits (6 at defaults) on every output address.
REQ-007 A READ SHALL be enqueued at the clock edge where it is presented; requests carry no handshake.
REQ-008 A READ arriving while the FIFO is full and no dequeue occurs that cycle SHALL be dropped and SHALL set overflow to 1 until reset.
REQ-009 Enqueue and dequeue in the same cycle SHALL both take effect; full/empty pointers SHALL wrap modulo REQ_DEPTH.
REQ-010 FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
REQ-011 IDLE: when the FIFO is non-empty, pop the head into a request register and go to MEM_REQ next cycle.
REQ-012 MEM_REQ: assert mem_req_valid with the aligned address; hold both stable until mem_req_ready; on valid&&ready go to MEM_WAIT.
REQ-013 MEM_WAIT: on mem_resp_valid, capture mem_resp_data and go to RESP; a mem_resp_valid in any other state SHALL be ignored.
REQ-014 RESP: drive l2_icache_op=001, aligned address, captured data, and state 0010 for exactly one cycle, then return to IDLE.
REQ-015 Minimum READ-to-FILL latency with ready=1 and resp one cycle after acceptance SHALL be 4 cycles.
REQ-016 An inv_valid pulse SHALL be captured in a one-entry pending register (aligned address); a new pulse while pending SHALL overwrite it.
REQ-017 A pending INV SHALL be issued as a one-cycle l2_icache_op=010 with state 0001 in any cycle the FSM is not in RESP, then cleared.
REQ-018 If FILL and a pending INV collide, FILL SHALL win and the INV SHALL be issued on the next cycle.
REQ-019 An INV matching an in-flight READ line SHALL NOT cancel the FILL; ordering SHALL be FILL then INV.
REQ-020 When l2_icache_op is NOP, l2_icache_addr, l2_icache_data and l2_icache_state SHALL be 0.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst low SHALL asynchronously force FSM=IDLE, FIFO empty, pending INV cleared, overflow=0, and every output to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it; no FILL SHALL be issued after release for any pre-reset request.
REQ-024 The first request SHALL be accepted on the first rising edge after rst goes high.

Verification
REQ-025 Single READ addr 0x00001010, ready=1, resp one cycle after acceptance with data all-0xA5 -> mem_req_addr 0x00001000; FILL 4 cycles later: addr 0x00001000, data all-0xA5, state 0010.
REQ-026 Three READs on consecutive cycles (0x1000, 0x2000, 0x3000), ready held 0 -> third dropped, overflow=1; after ready=1, exactly two FILLs, 0x1000 then 0x2000.
REQ-027 inv_valid addr 0x0000407F in the same cycle a FILL is due -> FILL that cycle, INV addr 0x00004040 state 0001 the next cycle.
REQ-028 Two inv_valid pulses (0x100 then 0x200) while FSM is in RESP -> exactly one INV, addr 0x200.
REQ-029 rst low during MEM_WAIT, then mem_resp_valid after release -> no FILL; all outputs 0; next READ completes normally.
REQ-030 mem_req_ready withheld 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles; one FILL after acceptance.
